// File: rtl/lcd_pkg.sv
// Shared constants and the arbiter state encoding for the LCD write path.
package lcd_pkg;

  localparam int unsigned LCD_NUM_REQ = 3;
  localparam int unsigned LCD_DATA_W  = 9;
  localparam int unsigned LCD_DC_BIT  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StWaitDone,
    StRelease
  } arb_state_e;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first eligible requester after rr_last, wrapping.
module lcd_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    onehot   = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(rr_last) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && eligible[cand_idx]) begin
        any              = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares one lcd_write byte engine among NUM_REQ requesters with round-robin grant,
// optional locked bursts, per-owner done pulses and a completion watchdog.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ   = LCD_NUM_REQ,
  parameter int unsigned DATA_W    = LCD_DATA_W,
  parameter int unsigned WD_CYCLES = 4096
) (
  input  logic                      sys_clk_50MHz,
  input  logic                      sys_rst_n,
  input  logic                      init_done,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        wr_valid,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         data,
  output logic                      en_write,
  input  logic                      wr_done,
  output logic                      err_drop,
  output logic                      err_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WD_CYCLES == 0) ? 0 : WD_CYCLES - 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    owner_q, rr_last_q, pick_idx;
  logic [WD_W-1:0]     wd_q;
  logic [NUM_REQ-1:0]  eligible, pick_onehot, drop_mask;
  logic                pick_any, forced_release, wd_expire;
  logic [DATA_W-1:0]   owner_word;

  lcd_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .eligible(eligible),
    .rr_last (rr_last_q),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    eligible       = init_done ? req : {{(NUM_REQ-1){1'b0}}, req[0]};
    owner_word     = wr_data[owner_q*DATA_W +: DATA_W];
    // Once init drops, a non-init owner must not keep the bus via lock.
    forced_release = !init_done && (owner_q != '0);
    wd_expire      = (WD_CYCLES != 0) && (wd_q == WD_LAST);
    // Only the owner, while waiting for its next word, may present data.
    drop_mask      = (state_q == StGrant) ? ~gnt : '1;
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_last_q   <= IDX_W'(NUM_REQ - 1);
      wd_q        <= '0;
      gnt         <= '0;
      req_done    <= '0;
      data        <= '0;
      en_write    <= 1'b0;
      err_drop    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_done <= '0;
      en_write <= 1'b0;
      if (|(wr_valid & drop_mask)) err_drop <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            gnt       <= pick_onehot;
            owner_q   <= pick_idx;
            rr_last_q <= pick_idx;
            state_q   <= StGrant;
          end
        end
        StGrant: begin
          if (wr_valid[owner_q]) begin
            data     <= owner_word;
            en_write <= 1'b1;
            wd_q     <= '0;
            state_q  <= StWaitDone;
          end else if (!req[owner_q] || forced_release) begin
            gnt     <= '0;
            state_q <= StRelease;
          end
        end
        StWaitDone: begin
          // Completion takes priority over a simultaneous watchdog expiry.
          if (wr_done) begin
            req_done[owner_q] <= 1'b1;
            if (lock[owner_q] && req[owner_q] && !forced_release) begin
              state_q <= StGrant;
            end else begin
              gnt     <= '0;
              state_q <= StRelease;
            end
          end else if (wd_expire) begin
            err_timeout <= 1'b1;
            gnt         <= '0;
            state_q     <= StRelease;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule
